// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  localparam int unsigned NUM_REQ_DEF = 2;
  localparam int unsigned TIMEOUT_DEF = 1023;

  // Index width for a requester number; never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first valid requester strictly after last_winner, wrapping.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      last_winner,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner    = last_winner;
    any_valid = 1'b0;
    idx       = '0;
    // Offset NUM_REQ lands back on last_winner, so it wins only when alone.
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = IW'((int'(last_winner) + k) % int'(NUM_REQ));
      if (!any_valid && req_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Optional START-state watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_start_clear,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        winner;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   win_oh;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 busy_q, busy_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_valid  (req_valid),
    .last_winner(last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign win_oh = NUM_REQ'(1) << winner;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    start_d = start_q;
    grant_d = grant_q;
    ready_d = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (any_valid) begin
          data_d  = req_data[{winner, 3'b000} +: 8];
          start_d = 1'b1;
          grant_d = win_oh;
          ready_d = win_oh;
          last_d  = winner;
          state_d = START;
        end
      end
      START: begin
        if (tx_start_clear) begin
          start_d = 1'b0;
          state_d = WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and flag it.
          start_d = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      WAIT: begin
        if (!tx_busy) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      start_q <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      start_q <= start_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign tx_data   = data_q;
  assign tx_start  = start_q;
  assign grant     = grant_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against a transfer-level reference model, plus directed cases.
module tb_uart_tx_arb;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_start_clear;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_start_clear(tx_start_clear),
    .tx_busy       (tx_busy),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: one transfer owner at a time ----------------
  int           m_owner;   // -1 when no transfer in flight
  int           m_last;
  int           m_cnt;
  bit           m_start;
  bit           m_err;
  logic [7:0]   m_data;
  logic [N-1:0] m_ready;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_cnt = 0; m_start = 0; m_err = 0;
    m_data = 8'h00; m_ready = '0;
  endtask

  task automatic model_step();
    int w;
    m_ready = '0;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
      if (w >= 0) begin
        m_owner = w; m_last = w; m_data = req_data[8*w +: 8];
        m_start = 1; m_ready[w] = 1'b1; m_cnt = 0;
      end
    end else if (m_start) begin
      if (tx_start_clear) m_start = 0;
      else begin
        m_cnt++;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (m_cnt == TO) begin m_start = 0; m_owner = -1; m_err = 1; end
`endif
      end
    end else if (!tx_busy) begin
      m_owner = -1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      logic [N-1:0] mg;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      mg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("cycle{start,data,grant,ready,busy,err}",
          32'({tx_start, tx_data, grant, req_ready, busy, timeout_err}),
          32'({m_start, m_data, mg, m_ready, (m_owner >= 0), m_err}));
    end
  end

  // ---------------- transmitter model ----------------
  int x_delay = 0;    // cycles before acknowledging; -1 picks randomly
  int x_blen  = 3;    // busy length; -1 picks randomly
  bit x_never = 0;
  bit x_noise = 0;
  int x_phase = 0;
  int x_cnt   = 0;
  int x_left  = 0;

  initial begin
    tx_start_clear = 1'b0;
    tx_busy        = 1'b0;
    forever begin
      @(negedge clk);
      tx_start_clear = 1'b0;
      if (!rst_n) begin
        x_phase = 0; tx_busy = 1'b0;
      end else begin
        if (x_phase == 0 && tx_start) begin
          x_cnt = (x_delay < 0) ? int'($urandom_range(0, 4)) : x_delay;
          x_phase = 1;
        end else if (x_phase == 0 && x_noise && $urandom_range(0, 3) == 0) begin
          tx_start_clear = 1'b1;
        end
        if (x_phase == 1) begin
          if (!tx_start) x_phase = 0;
          else if (x_cnt == 0) begin
            if (!x_never) begin
              tx_start_clear = 1'b1;
              x_phase = 2;
              x_left = (x_blen < 0) ? int'($urandom_range(0, 6)) : x_blen;
            end
          end else x_cnt--;
        end else if (x_phase == 2) begin
          if (x_left > 0) begin tx_busy = 1'b1; x_left--; end
          else begin tx_busy = 1'b0; x_phase = 0; end
          if (x_noise && $urandom_range(0, 3) == 0) tx_start_clear = 1'b1;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_rise(input string name);
    bit prev, seen;
    prev = tx_start; seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #2;
      if (tx_start && !prev) seen = 1;
      prev = tx_start;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #2;
      if (!busy && !tx_start) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    int ready1;
    logic [7:0] seq_d [4];
    logic [N-1:0] seq_g [4];

    rst_n = 1'b0; req_valid = '0; req_data = '0;
    @(posedge clk); #2;
    chk("reset_outputs", 32'({tx_start, tx_data, grant, req_ready, busy, timeout_err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single requester: one-cycle latency.
    x_delay = 0; x_blen = 3;
    @(negedge clk); req_valid = 3'b001; req_data[7:0] = 8'h41;
    @(posedge clk); #2;
    chk("single_tx_start", 32'(tx_start), 32'd1);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    chk("single_grant", 32'(grant), 32'b001);
    chk("single_ready", 32'(req_ready), 32'b001);
    @(negedge clk); req_valid = '0;
    @(posedge clk); #2;
    chk("single_ready_pulse", 32'(req_ready), 32'd0);
    wait_idle();

    // Delayed acknowledge: tx_start high 6 cycles, 5 WAIT cycles, one IDLE gap.
    x_delay = 5; x_blen = 4;
    @(negedge clk); req_valid = 3'b010; req_data[15:8] = 8'h77;
    wait_rise("hs");
    cnt = 0;
    while (tx_start && cnt < 50) begin cnt++; @(posedge clk); #2; end
    chk("hs_start_cycles", 32'(cnt), 32'd6);
    cnt = 0;
    while (busy && cnt < 50) begin cnt++; @(posedge clk); #2; end
    chk("hs_wait_cycles", 32'(cnt), 32'd5);
    cnt = 0;
    while (!tx_start && cnt < 50) begin cnt++; @(posedge clk); #2; end
    chk("hs_idle_gap", 32'(cnt), 32'd1);
    @(negedge clk); req_valid = '0;
    wait_idle();

    // Contention: A0/B1 alternate.
    x_delay = 0; x_blen = 20;
    @(negedge clk); req_valid = 3'b011; req_data[7:0] = 8'hA0; req_data[15:8] = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      wait_rise("rr");
      seq_d[i] = tx_data; seq_g[i] = grant;
    end
    @(negedge clk); req_valid = '0;
    chk("rr_data0", 32'(seq_d[0]), 32'hA0);
    chk("rr_data1", 32'(seq_d[1]), 32'hB1);
    chk("rr_data2", 32'(seq_d[2]), 32'hA0);
    chk("rr_data3", 32'(seq_d[3]), 32'hB1);
    chk("rr_grant0", 32'(seq_g[0]), 32'b001);
    chk("rr_grant1", 32'(seq_g[1]), 32'b010);
    chk("rr_grant3", 32'(seq_g[3]), 32'b010);
    wait_idle();

    // Reset in WAIT: asynchronous clear; requester 0 wins afterwards.
    x_delay = 0; x_blen = 30;
    @(negedge clk); req_valid = 3'b001; req_data[7:0] = 8'h55;
    wait_rise("rst");
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    #2; rst_n = 1'b0; #1;
    chk("rst_async_outputs", 32'({tx_start, tx_data, grant, req_ready, busy, timeout_err}), 32'd0);
    @(negedge clk); req_valid = 3'b011;
    @(negedge clk); rst_n = 1'b1;
    x_blen = 2;
    wait_rise("rst_after");
    chk("rst_next_grant", 32'(grant), 32'b001);
    @(negedge clk); req_valid = '0;
    wait_idle();

    // Withdrawal: requester 1 pulses valid during requester 0 transfer.
    x_delay = 6; x_blen = 2;
    @(negedge clk); req_valid = 3'b001; req_data[7:0] = 8'h12;
    wait_rise("wd");
    @(negedge clk); req_valid = 3'b010;
    repeat (2) @(negedge clk);
    req_valid = '0;
    ready1 = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (req_ready[1] || grant[1]) ready1++;
    end
    chk("withdraw_no_req1", 32'(ready1), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    x_never = 1; x_delay = 0;
    @(negedge clk); req_valid = 3'b001; req_data[7:0] = 8'h99;
    wait_rise("to");
    @(negedge clk); req_valid = '0;
    @(posedge clk); #2;
    cnt = 1;
    while (tx_start && cnt < 100) begin cnt++; @(posedge clk); #2; end
    chk("to_start_cycles", 32'(cnt), 32'(TO));
    chk("to_err_set", 32'(timeout_err), 32'd1);
    x_never = 0;
    @(negedge clk); req_valid = 3'b010; req_data[15:8] = 8'h3C;
    wait_rise("to_next");
    chk("to_next_grant", 32'(grant), 32'b010);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    @(negedge clk); req_valid = '0;
    wait_idle();
`endif

    // Randomized traffic with acknowledge noise and occasional resets.
    x_delay = -1; x_blen = -1; x_noise = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      req_valid = N'($urandom_range(0, 7));
      req_data  = (8*N)'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk); req_valid = '0; x_noise = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
